// File: rtl/rx_byte_fifo.sv
// First-word-fall-through receive buffer between the UART RX datapath and the host.
// Stores each byte with its framing-error bit, and reports occupancy, almost-full and sticky overrun.
module rx_byte_fifo #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ALMOST_FULL = 12
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       wr_valid,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic                       wr_frame_err,
  input  logic                       flush,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       rd_frame_err,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic                       overrun,
  input  logic                       clr_overrun
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = DATA_WIDTH + 1;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [EW-1:0] head;
  logic          pop;
  logic          push;
  logic          drop;

  // Status flags are decoded straight from the count register.
  assign empty       = (count == CW'(0));
  assign full        = (count == CW'(DEPTH));
  assign almost_full = (count >= CW'(ALMOST_FULL));
  assign rd_valid    = !empty;

  // A full queue still accepts a byte when the head leaves in the same cycle.
  assign pop  = rd_valid & rd_ready;
  assign push = wr_valid & (!full | pop);
  assign drop = wr_valid & full & !pop;

  assign head         = mem[rd_ptr];
  assign rd_data      = empty ? '0 : head[DATA_WIDTH-1:0];
  assign rd_frame_err = empty ? 1'b0 : head[DATA_WIDTH];

  // Storage is intentionally left without reset.
  always_ff @(posedge clock) begin
    if (reset_n && !flush && push) begin
      mem[wr_ptr] <= {wr_frame_err, wr_data};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // A byte lost to a full queue outranks a simultaneous clear; flushed bytes never count as lost.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if (drop && !flush) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Self-checking bench for rx_byte_fifo: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_rx_byte_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AF    = 12;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_frame_err;
  logic          flush;
  logic          rd_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_frame_err;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          almost_full;
  logic          overrun;
  logic          clr_overrun;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of {frame_err, byte} entries plus the sticky flag.
  logic [DW:0] mq[$];
  logic        m_ovr;

  always #5 clock = ~clock;

  rx_byte_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ALMOST_FULL(AF)) dut (
    .clock(clock), .reset_n(reset_n), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_frame_err(wr_frame_err), .flush(flush), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_frame_err(rd_frame_err),
    .count(count), .empty(empty), .full(full), .almost_full(almost_full),
    .overrun(overrun), .clr_overrun(clr_overrun)
  );

  function automatic logic [DW-1:0] exp_data();
    logic [DW:0] e;
    if (mq.size() == 0) return '0;
    e = mq[0];
    return e[DW-1:0];
  endfunction

  function automatic logic exp_fe();
    logic [DW:0] e;
    if (mq.size() == 0) return 1'b0;
    e = mq[0];
    return e[DW];
  endfunction

  // Drive one cycle of inputs, advance the model by the same rules, sample 1 time unit after the edge.
  task automatic cycle(input logic rst, input logic wv, input logic [DW-1:0] wd,
                       input logic fe, input logic fl, input logic rr, input logic clr);
    logic was_full, do_pop, do_push;
    reset_n = !rst; wr_valid = wv; wr_data = wd; wr_frame_err = fe;
    flush = fl; rd_ready = rr; clr_overrun = clr;
    if (rst) begin
      mq.delete(); m_ovr = 1'b0;
    end else begin
      was_full = (mq.size() == DEPTH);
      do_pop   = (mq.size() > 0) && rr;
      do_push  = wv && (!was_full || do_pop);
      if (wv && was_full && !do_pop && !fl) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
      if (fl) mq.delete();
      else begin
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back({fe, wd});
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic push_byte(input logic [DW-1:0] d, input logic fe);
    cycle(1'b0, 1'b1, d, fe, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== '0 || rd_frame_err !== 1'b0 || count !== '0 ||
        empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset: valid=%b data=%h fe=%b count=%0d empty=%b full=%b af=%b ovr=%b, need 0 00 0 0 1 0 0 0",
               rd_valid, rd_data, rd_frame_err, count, empty, full, almost_full, overrun);
    end
  endtask

  task automatic test_single();
    push_byte(8'hA5, 1'b0);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || count !== CW'(1)) begin
      errors++;
      $display("FAIL single_push: valid=%b data=%h count=%0d, need 1 a5 1", rd_valid, rd_data, count);
    end
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (empty !== 1'b1 || rd_data !== '0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pop: empty=%b data=%h valid=%b, need 1 00 0", empty, rd_data, rd_valid);
    end
    // rd_ready on an empty queue must be harmless
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (count !== '0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL empty_read: count=%0d empty=%b, need 0 1", count, empty);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      push_byte(DW'(i), 1'b0);
      checks++;
      if (count !== CW'(i + 1) || almost_full !== (i + 1 >= AF) || full !== (i + 1 == DEPTH) ||
          rd_data !== 8'h00) begin
        errors++;
        $display("FAIL fill[%0d]: count=%0d af=%b full=%b head=%h, need %0d %b %b 00",
                 i, count, almost_full, full, rd_data, i + 1, i + 1 >= AF, i + 1 == DEPTH);
      end
    end
  endtask

  task automatic test_overrun();
    push_byte(8'h55, 1'b0);
    checks++;
    if (count !== CW'(DEPTH) || overrun !== 1'b1 || rd_data !== 8'h00) begin
      errors++;
      $display("FAIL overrun_set: count=%0d ovr=%b head=%h, need 16 1 00", count, overrun, rd_data);
    end
    cycle(1'b0, 1'b1, 8'h56, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set_wins: ovr=%b, need 1", overrun);
    end
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (overrun !== 1'b0 || count !== CW'(DEPTH)) begin
      errors++;
      $display("FAIL overrun_clear: ovr=%b count=%0d, need 0 16", overrun, count);
    end
  endtask

  task automatic test_back_to_back();
    cycle(1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (count !== CW'(DEPTH) || rd_data !== 8'h01 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL push_pop_full: count=%0d head=%h ovr=%b, need 16 01 0", count, rd_data, overrun);
    end
    for (int i = 0; i < DEPTH; i++) begin
      logic [DW-1:0] want;
      want = (i == DEPTH - 1) ? 8'h77 : DW'(i + 1);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== want || rd_data !== exp_data()) begin
        errors++;
        $display("FAIL drain[%0d]: valid=%b data=%h, need 1 %h", i, rd_valid, rd_data, want);
      end
      cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    checks++;
    if (empty !== 1'b1 || count !== '0) begin
      errors++;
      $display("FAIL drain_end: empty=%b count=%0d, need 1 0", empty, count);
    end
  endtask

  task automatic test_frame_err();
    push_byte(8'h3C, 1'b1);
    push_byte(8'h3D, 1'b0);
    checks++;
    if (rd_data !== 8'h3C || rd_frame_err !== 1'b1) begin
      errors++;
      $display("FAIL frame_err_first: data=%h fe=%b, need 3c 1", rd_data, rd_frame_err);
    end
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (rd_data !== 8'h3D || rd_frame_err !== 1'b0) begin
      errors++;
      $display("FAIL frame_err_second: data=%h fe=%b, need 3d 0", rd_data, rd_frame_err);
    end
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_flush();
    logic ovr_before;
    for (int i = 0; i < 5; i++) push_byte(DW'($urandom), 1'b0);
    ovr_before = m_ovr;
    cycle(1'b0, 1'b1, 8'hEE, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (count !== '0 || empty !== 1'b1 || overrun !== ovr_before || rd_data !== '0) begin
      errors++;
      $display("FAIL flush: count=%0d empty=%b ovr=%b data=%h, need 0 1 %b 00",
               count, empty, overrun, rd_data, ovr_before);
    end
    // A dropped byte sets overrun; a flush the cycle after must leave it set.
    for (int i = 0; i < DEPTH + 1; i++) push_byte(DW'(i), 1'b0);
    cycle(1'b0, 1'b1, 8'h99, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (overrun !== 1'b1 || count !== '0) begin
      errors++;
      $display("FAIL flush_keeps_overrun: ovr=%b count=%0d, need 1 0", overrun, count);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < DEPTH / 2; i++) push_byte(DW'($urandom), 1'b1);
    cycle(1'b1, 1'b1, 8'h12, 1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== '0 || rd_frame_err !== 1'b0 || count !== '0 ||
        empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: valid=%b data=%h fe=%b count=%0d empty=%b full=%b af=%b ovr=%b",
               rd_valid, rd_data, rd_frame_err, count, empty, full, almost_full, overrun);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      logic rst, wv, fe, fl, rr, clr;
      rst = ($urandom_range(0, 299) == 0);
      wv  = ($urandom_range(0, 99) < 55);
      fe  = ($urandom_range(0, 7) == 0);
      fl  = ($urandom_range(0, 149) == 0);
      rr  = ($urandom_range(0, 99) < 45);
      clr = ($urandom_range(0, 19) == 0);
      cycle(rst, wv, DW'($urandom), fe, fl, rr, clr);
      checks++;
      if (count !== CW'(mq.size()) || rd_valid !== (mq.size() != 0) || rd_data !== exp_data() ||
          rd_frame_err !== exp_fe() || empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH) ||
          almost_full !== (mq.size() >= AF) || overrun !== m_ovr) begin
        errors++;
        $display("FAIL random[%0d]: count=%0d data=%h fe=%b af=%b full=%b ovr=%b, need %0d %h %b %b %b %b",
                 n, count, rd_data, rd_frame_err, almost_full, full, overrun,
                 mq.size(), exp_data(), exp_fe(), mq.size() >= AF, mq.size() == DEPTH, m_ovr);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_frame_err = 1'b0;
    flush = 1'b0; rd_ready = 1'b0; clr_overrun = 1'b0; m_ovr = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_overrun();
    test_back_to_back();
    test_frame_err();
    test_flush();
    test_reset();
    test_reset_mid();
    idle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
